mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 103 ++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer driving a split addr/data handshake dbus.
// Misaligned or illegal-size ops and ops with no bus access complete without a bus request.
module mem_access_unit #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_load,
   input  logic              in_store,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic              flush,
   output logic              req_valid,
   output logic [ADDR_W-1:0] req_addr,
   output logic [1:0]        req_size,
   output logic [DATA_W/8-1:0] req_strobe,
   output logic [DATA_W-1:0] req_data,
   input  logic              resp_addr_ok,
   input  logic              resp_data_ok,
   input  logic [DATA_W-1:0] resp_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              exc_valid,
   output logic [3:0]        exc_code,
   output logic              busy
);
   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);
   localparam logic [NB-1:0] S1 = 1;
   localparam logic [DATA_W-1:0] D1 = 1;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0] size_q;
   logic uns_q, store_q, kill_q, exc_q;
   logic [3:0] code_q;
   logic [DATA_W-1:0] wdata_q, res_q;
   logic acc, is_ld, is_st, mis, bad_sz, exc_in, dok, done_ok, sgn;
   logic [3:0] code_in;
   logic [OW-1:0] off;
   logic [NB-1:0] strobe_v;
   logic [DATA_W-1:0] wshift, sh, fmask, ld_v;
   assign acc     = (state == IDLE) && in_valid && !flush;
   assign is_ld   = in_load;
   assign is_st   = in_store && !in_load;
   assign mis     = |(in_addr[2:0] & ((3'd1 << in_size) - 3'd1));
   assign bad_sz  = (DATA_W == 32) && (in_size == 2'd3);
   assign exc_in  = (is_ld || is_st) && (mis || bad_sz);
   assign code_in = {2'b01, is_st, bad_sz};
   assign off      = addr_q[OW-1:0];
   assign strobe_v = ((S1 << (4'd1 << size_q)) - S1) << off;
   assign wshift   = wdata_q << {off, 3'b000};
   assign sh       = resp_data >> {off, 3'b000};
   // fmask covers the 2^size low bytes; its top bit selects the sign bit.
   assign fmask    = (D1 << (32'd8 << size_q)) - D1;
   assign sgn      = !uns_q && |(sh & (fmask ^ (fmask >> 1)));
   assign ld_v     = (sh & fmask) | ({DATA_W{sgn}} & ~fmask);
   assign dok      = (state == REQ && resp_addr_ok && resp_data_ok) || (state == WAIT && resp_data_ok);
   always_comb begin
      state_n    = state;
      req_valid  = !reset && state == REQ;
      req_addr   = req_valid ? addr_q : '0;
      req_size   = req_valid ? size_q : '0;
      req_strobe = (req_valid && store_q) ? strobe_v : '0;
      req_data   = req_valid ? wshift : '0;
      done_ok    = !reset && state == DONE && !kill_q && !flush;
      out_valid  = done_ok;
      out_data   = done_ok ? res_q : '0;
      exc_valid  = done_ok && exc_q;
      exc_code   = exc_valid ? code_q : '0;
      busy       = !reset && (state != IDLE || (in_valid && !flush)) && state != DONE;
      case (state)
         IDLE:    if (acc) state_n = (exc_in || !(is_ld || is_st)) ? DONE : REQ;
         REQ:     if (resp_addr_ok) state_n = resp_data_ok ? DONE : WAIT;
         WAIT:    if (resp_data_ok) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         kill_q <= 1'b0;
      end else begin
         state  <= state_n;
         kill_q <= (state == DONE) ? 1'b0 : kill_q | (flush && (state == REQ || state == WAIT));
         if (acc) begin
            addr_q  <= in_addr;
            size_q  <= in_size;
            uns_q   <= in_unsigned;
            store_q <= is_st;
            wdata_q <= in_wdata;
            exc_q   <= exc_in;
            code_q  <= code_in;
            res_q   <= '0;
         end
         if (dok && !store_q) res_q <= ld_v;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store ops against a byte-level reference model,
// plus a DATA_W=32 instance for the illegal-size and narrow-bus paths.
module tb_mem_access_unit;
   logic clk = 0, reset = 1;
   always #5 clk = ~clk;
   logic in_valid = 0, in_load = 0, in_store = 0, in_unsigned = 0, flush = 0;
   logic resp_addr_ok = 0, resp_data_ok = 0;
   logic [1:0] in_size = 0;
   logic [63:0] in_addr = 0, in_wdata = 0, resp_data = 0;
   logic req_valid, out_valid, exc_valid, busy;
   logic [63:0] req_addr, req_data, out_data;
   logic [1:0] req_size;
   logic [7:0] req_strobe;
   logic [3:0] exc_code;
   logic s_in_valid = 0, s_in_load = 0, s_in_store = 0, s_in_unsigned = 0;
   logic s_resp_addr_ok = 0, s_resp_data_ok = 0;
   logic [1:0] s_in_size = 0;
   logic [31:0] s_in_addr = 0, s_in_wdata = 0, s_resp_data = 0;
   logic s_req_valid, s_out_valid, s_exc_valid, s_busy;
   logic [31:0] s_req_addr, s_req_data, s_out_data;
   logic [1:0] s_req_size;
   logic [3:0] s_req_strobe, s_exc_code;
   int n_vec = 0, n_err = 0;

   mem_access_unit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .flush(flush), .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
      .req_strobe(req_strobe), .req_data(req_data), .resp_addr_ok(resp_addr_ok),
      .resp_data_ok(resp_data_ok), .resp_data(resp_data), .out_valid(out_valid),
      .out_data(out_data), .exc_valid(exc_valid), .exc_code(exc_code), .busy(busy));

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_load(s_in_load), .in_store(s_in_store),
      .in_size(s_in_size), .in_unsigned(s_in_unsigned), .in_addr(s_in_addr), .in_wdata(s_in_wdata),
      .flush(1'b0), .req_valid(s_req_valid), .req_addr(s_req_addr), .req_size(s_req_size),
      .req_strobe(s_req_strobe), .req_data(s_req_data), .resp_addr_ok(s_resp_addr_ok),
      .resp_data_ok(s_resp_data_ok), .resp_data(s_resp_data), .out_valid(s_out_valid),
      .out_data(s_out_data), .exc_valid(s_exc_valid), .exc_code(s_exc_code), .busy(s_busy));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] ld_model(logic [63:0] rd, int off, int sz, bit un);
      logic [63:0] v;
      int n;
      v = rd >> (8 * off);
      n = 8 << sz;
      if (n < 64) begin
         v = v % (64'd1 << n);
         if (!un && v >= (64'd1 << (n - 1))) v = v - (64'd1 << n);
      end
      return v;
   endfunction

   function automatic logic [7:0] strb_model(int off, int sz);
      logic [7:0] s;
      s = 0;
      for (int b = 0; b < (1 << sz); b++) if (off + b < 8) s[off + b] = 1'b1;
      return s;
   endfunction

   task automatic run_op(input bit ld, input bit st, input logic [1:0] sz, input bit un,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                         input int a_dly, input int d_dly, input int fl_at, input string t);
      bit is_ld, is_st, mis, legal, ex, killed;
      int off, cyc;
      logic [3:0] code;
      logic [63:0] res;
      is_ld = ld;
      is_st = st && !ld;
      off   = int'(a % 8);
      mis   = (a % (64'd1 << sz)) != 0;
      legal = (is_ld || is_st) && !mis;
      ex    = (is_ld || is_st) && mis;
      code  = is_ld ? 4'd4 : 4'd6;
      res   = (is_ld && legal) ? ld_model(rd, off, int'(sz), un) : 64'd0;
      cyc   = 1;
      @(negedge clk);
      in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_unsigned = un;
      in_addr = a; in_wdata = wd; flush = 0;
      resp_addr_ok = 1'($urandom % 2); resp_data_ok = 1'($urandom % 2); resp_data = rnd64();
      #1;
      chk({t, "_acc_busy"}, busy, 1);
      chk({t, "_acc_rv"}, req_valid, 0);
      chk({t, "_acc_ov"}, out_valid, 0);
      if (legal) begin
         for (int i = 0; i <= a_dly; i++) begin
            @(negedge clk);
            resp_addr_ok = (i == a_dly);
            resp_data_ok = (i == a_dly) ? (d_dly == 0) : 1'($urandom % 2);
            resp_data = (i == a_dly && d_dly == 0) ? rd : rnd64();
            flush = (cyc == fl_at);
            #1;
            chk({t, "_req_rv"}, req_valid, 1);
            chk({t, "_req_addr"}, req_addr, a);
            chk({t, "_req_size"}, req_size, sz);
            chk({t, "_req_strobe"}, req_strobe, is_st ? strb_model(off, int'(sz)) : 8'h00);
            if (is_st) chk({t, "_req_data"}, req_data, wd << (8 * off));
            chk({t, "_req_busy"}, busy, 1);
            chk({t, "_req_ov"}, out_valid, 0);
            cyc++;
         end
         for (int j = 1; j <= d_dly; j++) begin
            @(negedge clk);
            resp_addr_ok = 1'($urandom % 2);
            resp_data_ok = (j == d_dly);
            resp_data = (j == d_dly) ? rd : rnd64();
            flush = (cyc == fl_at);
            #1;
            chk({t, "_wait_rv"}, req_valid, 0);
            chk({t, "_wait_busy"}, busy, 1);
            chk({t, "_wait_ov"}, out_valid, 0);
            cyc++;
         end
      end
      @(negedge clk);
      resp_addr_ok = 1'($urandom % 2); resp_data_ok = 1'($urandom % 2); resp_data = rnd64();
      flush = (cyc == fl_at);
      killed = fl_at >= 1 && fl_at <= cyc;
      #1;
      chk({t, "_done_ov"}, out_valid, !killed);
      chk({t, "_done_ev"}, exc_valid, !killed && ex);
      chk({t, "_done_ec"}, exc_code, (!killed && ex) ? code : 4'd0);
      chk({t, "_done_od"}, out_data, killed ? 64'd0 : res);
      chk({t, "_done_busy"}, busy, 0);
      chk({t, "_done_rv"}, req_valid, 0);
   endtask

   task automatic go_idle(input string t);
      @(negedge clk);
      in_valid = 0; flush = 0; resp_addr_ok = 0; resp_data_ok = 0;
      #1;
      chk({t, "_idle_busy"}, busy, 0);
      chk({t, "_idle_rv"}, req_valid, 0);
      chk({t, "_idle_ov"}, out_valid, 0);
   endtask

   initial begin
      int kind, ad, dd, fl;
      logic [1:0] sz;
      logic [63:0] a;
      @(negedge clk);
      in_valid = 1; in_load = 1; in_size = 2; in_addr = 64'h100;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rv", req_valid, 0);
      chk("rst_raddr", req_addr, 0);
      chk("rst_rstrb", req_strobe, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_od", out_data, 0);
      chk("rst_ev", exc_valid, 0);
      chk("rst_ec", exc_code, 0);
      @(negedge clk);
      reset = 0; in_valid = 0;
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rv", req_valid, 0);

      run_op(1, 0, 0, 0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, -1, "lb");
      go_idle("lb");
      run_op(0, 1, 1, 0, 64'h2006, 64'hABCD, rnd64(), 3, 2, -1, "sh");
      go_idle("sh");
      run_op(1, 0, 2, 0, 64'h1002, 64'd0, rnd64(), 0, 0, -1, "lw_mis");
      run_op(0, 1, 3, 0, 64'h1004, rnd64(), rnd64(), 0, 0, -1, "sd_mis");
      run_op(0, 0, 2, 0, 64'h1000, rnd64(), rnd64(), 0, 0, -1, "noacc");
      go_idle("exc");
      run_op(1, 0, 2, 0, 64'h3000, 64'd0, rnd64(), 1, 3, 3, "fl_wait");
      run_op(1, 0, 2, 1, 64'h3004, 64'd0, rnd64(), 0, 1, -1, "after_fl");
      run_op(0, 1, 0, 0, 64'h3001, rnd64(), rnd64(), 2, 0, 1, "fl_req");
      run_op(1, 0, 3, 0, 64'h3008, 64'd0, rnd64(), 0, 0, 2, "fl_done");
      run_op(1, 0, 1, 0, 64'h3001, 64'd0, rnd64(), 0, 0, 1, "fl_exc");
      go_idle("fl");

      @(negedge clk);
      in_valid = 1; in_load = 1; in_store = 0; in_size = 2; in_addr = 64'h5000; flush = 1;
      #1;
      chk("fl_idle_busy", busy, 0);
      @(negedge clk);
      in_valid = 0; flush = 0;
      #1;
      chk("fl_idle_rv", req_valid, 0);
      chk("fl_idle_busy2", busy, 0);

      @(negedge clk);
      in_valid = 1; in_addr = 64'h4000;
      #1;
      chk("rw_acc_busy", busy, 1);
      @(negedge clk);
      resp_addr_ok = 1; resp_data_ok = 0;
      #1;
      chk("rw_req_rv", req_valid, 1);
      @(negedge clk);
      resp_addr_ok = 0; reset = 1;
      #1;
      chk("rw_rst_busy", busy, 0);
      chk("rw_rst_rv", req_valid, 0);
      chk("rw_rst_ov", out_valid, 0);
      chk("rw_rst_od", out_data, 0);
      @(negedge clk);
      reset = 0; in_valid = 0; resp_data_ok = 1; resp_data = rnd64();
      #1;
      chk("rw_idle_busy", busy, 0);
      chk("rw_idle_rv", req_valid, 0);
      chk("rw_idle_raddr", req_addr, 0);
      chk("rw_idle_ov", out_valid, 0);
      @(negedge clk);
      resp_data_ok = 0;
      #1;
      chk("rw_stale_ov", out_valid, 0);
      chk("rw_stale_ev", exc_valid, 0);
      chk("rw_stale_busy", busy, 0);

      run_op(1, 0, 0, 1, 64'h0, 64'd0, 64'h1122_3344_5566_7788, 0, 0, -1, "lbu0");
      run_op(1, 0, 0, 1, 64'h7, 64'd0, 64'h1122_3344_5566_7788, 1, 1, -1, "lbu7");
      go_idle("lbu");

      for (int k = 0; k < 120; k++) begin
         kind = int'($urandom % 4);
         sz = 2'($urandom % 4);
         a = rnd64();
         if ($urandom % 4 != 0) a = a & ~((64'd1 << sz) - 64'd1);
         ad = int'($urandom % 4);
         dd = int'($urandom % 4);
         fl = ($urandom % 8 == 0) ? 1 + int'($urandom % 32'(ad + dd + 2)) : -1;
         run_op(kind == 0 || kind == 3, kind == 1 || kind == 3, sz, 1'($urandom % 2), a,
                rnd64(), rnd64(), ad, dd, fl, "rnd");
         if ($urandom % 3 == 0) go_idle("rnd");
      end
      go_idle("end64");

      @(negedge clk);
      s_in_valid = 1; s_in_load = 1; s_in_store = 0; s_in_size = 3; s_in_addr = 32'h1000;
      #1;
      chk("w32_ld_busy", s_busy, 1);
      @(negedge clk);
      #1;
      chk("w32_ld_rv", s_req_valid, 0);
      chk("w32_ld_ov", s_out_valid, 1);
      chk("w32_ld_ev", s_exc_valid, 1);
      chk("w32_ld_ec", s_exc_code, 5);
      @(negedge clk);
      s_in_load = 0; s_in_store = 1;
      #1;
      chk("w32_sd_busy", s_busy, 1);
      @(negedge clk);
      #1;
      chk("w32_sd_ev", s_exc_valid, 1);
      chk("w32_sd_ec", s_exc_code, 7);
      @(negedge clk);
      s_in_load = 1; s_in_store = 0; s_in_size = 1; s_in_unsigned = 0; s_in_addr = 32'h2002;
      @(negedge clk);
      s_resp_addr_ok = 1; s_resp_data_ok = 1; s_resp_data = 32'h8001_0000;
      #1;
      chk("w32_lh_rv", s_req_valid, 1);
      chk("w32_lh_rstrb", s_req_strobe, 0);
      @(negedge clk);
      s_resp_addr_ok = 0; s_resp_data_ok = 0;
      #1;
      chk("w32_lh_ov", s_out_valid, 1);
      chk("w32_lh_od", s_out_data, 32'(ld_model(64'h8001_0000, 2, 1, 0)));
      chk("w32_lh_ev", s_exc_valid, 0);
      @(negedge clk);
      s_in_valid = 0;
      #1;
      chk("w32_idle_busy", s_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
